// File: rtl/m_stage_dmem_pkg.sv
// rtl/m_stage_dmem_pkg.sv - shared memory-type, FSM state and exception codes for the M stage
package m_stage_dmem_pkg;

  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_BYTE = 2'b10;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Code 11 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] mt, input logic [1:0] addr_lo);
    case (mt)
      MT_HALF: return addr_lo[0];
      MT_BYTE: return 1'b0;
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/m_stage_dmem_store_align.sv
// rtl/m_stage_dmem_store_align.sv - store byte-enable and replicated write-data generation
module store_align
  import m_stage_dmem_pkg::*;
(
  input  logic [1:0]  mem_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wd_i;
    case (mem_type_i)
      MT_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wd_i[15:0]}};
      end
      MT_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wd_i[7:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wd_i;
      end
    endcase
  end

endmodule

// File: rtl/m_stage_dmem.sv
// rtl/m_stage_dmem.sv - memory stage: data-memory bus master and M/W pipeline register
// Optional misalignment trapping is enabled by defining M_ALIGN_CHECK_EN.
module m_stage_dmem
  import m_stage_dmem_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_M_I,
  input  logic [31:0] PC_M_I,
  input  logic [31:0] ALURS_M_I,
  input  logic [31:0] WD_M_I,
  input  logic [4:0]  Dst_M_I,
  input  logic        MemRd_M_I,
  input  logic        MemWr_M_I,
  input  logic [1:0]  Mem_type_M_I,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        Stall_M_O,
  output logic [31:0] Instr_W_O,
  output logic [31:0] PC_W_O,
  output logic [31:0] ALURS_W_O,
  output logic [31:0] RD_W_O,
  output logic [31:0] WD_W_O,
  output logic [4:0]  Dst_W_O,
  output logic [4:0]  ExcCode_W_O
);

  state_e      state_q, state_d;
  logic        we_q, bubble, bus_load, mem_op, mis_align, access;
  logic [31:0] addr_q, wdata_q, hold_q;
  logic [3:0]  be_q, be_s;
  logic [31:0] wdata_s;
  logic [31:0] instr_q, pc_q, alurs_q, rd_q, wd_q;
  logic [4:0]  dst_q, exc_q, exc_d;

  assign mem_op = MemRd_M_I | MemWr_M_I;

`ifdef M_ALIGN_CHECK_EN
  // A misaligned op skips the bus entirely and flows to W carrying its exception.
  assign mis_align = mem_op & misaligned(Mem_type_M_I, ALURS_M_I[1:0]);
  assign exc_d     = mis_align ? (MemWr_M_I ? EXC_ADES : EXC_ADEL) : EXC_NONE;
`else
  assign mis_align = 1'b0;
  assign exc_d     = EXC_NONE;
`endif

  assign access = mem_op & ~mis_align;

  store_align u_store_align (
    .mem_type_i (Mem_type_M_I),
    .addr_lo_i  (ALURS_M_I[1:0]),
    .wd_i       (WD_M_I),
    .be_o       (be_s),
    .wdata_o    (wdata_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = ST_BUSY;
      ST_BUSY: if (dm_ready) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Stall_M_O = 1'b0;
    bubble    = 1'b0;
    bus_load  = 1'b0;
    dm_req    = 1'b0;
    case (state_q)
      ST_IDLE: if (access) begin
        Stall_M_O = 1'b1;
        bubble    = 1'b1;
        bus_load  = 1'b1;
      end
      ST_BUSY: begin
        Stall_M_O = 1'b1;
        bubble    = 1'b1;
        dm_req    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      alurs_q <= '0;
      rd_q    <= '0;
      wd_q    <= '0;
      dst_q   <= '0;
      exc_q   <= '0;
    end else begin
      if (bus_load) begin
        addr_q  <= {ALURS_M_I[31:2], 2'b00};
        we_q    <= MemWr_M_I;
        be_q    <= MemWr_M_I ? be_s : 4'b1111;
        wdata_q <= wdata_s;
      end
      if (state_q == ST_BUSY && dm_ready)
        hold_q <= we_q ? 32'h0 : dm_rdata;
      if (bubble) begin
        instr_q <= NOP_INSTR;
        dst_q   <= '0;
        exc_q   <= '0;
      end else begin
        instr_q <= Instr_M_I;
        pc_q    <= PC_M_I;
        alurs_q <= ALURS_M_I;
        wd_q    <= WD_M_I;
        dst_q   <= Dst_M_I;
        exc_q   <= exc_d;
        rd_q    <= (state_q == ST_DONE) ? hold_q : 32'h0;
      end
    end
  end

  assign dm_we       = we_q;
  assign dm_addr     = addr_q;
  assign dm_be       = be_q;
  assign dm_wdata    = wdata_q;
  assign Instr_W_O   = instr_q;
  assign PC_W_O      = pc_q;
  assign ALURS_W_O   = alurs_q;
  assign RD_W_O      = rd_q;
  assign WD_W_O      = wd_q;
  assign Dst_W_O     = dst_q;
  assign ExcCode_W_O = exc_q;

endmodule

// File: tb/tb_m_stage_dmem.sv
// tb/tb_m_stage_dmem.sv - scoreboard bench for m_stage_dmem (W entries and bus requests)
module tb_m_stage_dmem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_M_I, PC_M_I, ALURS_M_I, WD_M_I;
  logic [4:0]  Dst_M_I;
  logic        MemRd_M_I, MemWr_M_I;
  logic [1:0]  Mem_type_M_I;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        Stall_M_O;
  logic [31:0] Instr_W_O, PC_W_O, ALURS_W_O, RD_W_O, WD_W_O;
  logic [4:0]  Dst_W_O, ExcCode_W_O;

  m_stage_dmem dut (
    .clk(clk), .reset(reset),
    .Instr_M_I(Instr_M_I), .PC_M_I(PC_M_I), .ALURS_M_I(ALURS_M_I), .WD_M_I(WD_M_I),
    .Dst_M_I(Dst_M_I), .MemRd_M_I(MemRd_M_I), .MemWr_M_I(MemWr_M_I), .Mem_type_M_I(Mem_type_M_I),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .Stall_M_O(Stall_M_O),
    .Instr_W_O(Instr_W_O), .PC_W_O(PC_W_O), .ALURS_W_O(ALURS_W_O), .RD_W_O(RD_W_O),
    .WD_W_O(WD_W_O), .Dst_W_O(Dst_W_O), .ExcCode_W_O(ExcCode_W_O)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, alurs, rd, wd;
    logic [4:0]  dst, exc;
  } w_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        we;
    logic [3:0]  be;
  } bus_t;

  w_t   wq[$];
  bus_t bq[$];
  int   checks = 0;
  int   passes = 0;
  logic mon_en = 1'b0;
  logic prev_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // W-side monitor: every non-NOP instruction in W is one scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Instr_W_O != 32'h0) begin
        if (wq.size() == 0) chk("w_unexpected", Instr_W_O, 32'h0);
        else begin
          w_t e;
          e = wq.pop_front();
          chk("w_instr", Instr_W_O, e.instr);
          chk("w_pc",    PC_W_O,    e.pc);
          chk("w_alurs", ALURS_W_O, e.alurs);
          chk("w_rd",    RD_W_O,    e.rd);
          chk("w_wd",    WD_W_O,    e.wd);
          chk("w_dst",   {27'h0, Dst_W_O},     {27'h0, e.dst});
          chk("w_exc",   {27'h0, ExcCode_W_O}, {27'h0, e.exc});
        end
      end else begin
        chk("bubble_dst", {27'h0, Dst_W_O},     32'h0);
        chk("bubble_exc", {27'h0, ExcCode_W_O}, 32'h0);
      end
    end
  end

  // Bus-side monitor: each rising dm_req is one request.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dm_req && !prev_req) begin
        if (bq.size() == 0) chk("bus_unexpected", {31'h0, dm_req}, 32'h0);
        else begin
          bus_t b;
          b = bq.pop_front();
          chk("bus_addr", dm_addr, b.addr);
          chk("bus_we",   {31'h0, dm_we}, {31'h0, b.we});
          chk("bus_be",   {28'h0, dm_be}, {28'h0, b.be});
          if (b.we) chk("bus_wdata", dm_wdata, b.wdata);
        end
      end
      prev_req <= dm_req;
    end
  end

  task automatic drive_m(input logic [31:0] instr, pc, alurs, wd, input logic [4:0] dst,
                         input logic rd, wr, input logic [1:0] mt);
    Instr_M_I = instr; PC_M_I = pc; ALURS_M_I = alurs; WD_M_I = wd;
    Dst_M_I = dst; MemRd_M_I = rd; MemWr_M_I = wr; Mem_type_M_I = mt;
  endtask

  task automatic do_op(input string nm, input logic [31:0] instr, pc, alurs, wd,
                       input logic [4:0] dst, input logic rd, wr, input logic [1:0] mt,
                       input int waits, input logic [31:0] rdata, exp_rd,
                       input int exp_stalls, input logic bus, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [4:0] exp_exc);
    w_t   e;
    bus_t b;
    int   nst = 0;
    int   req_seen = 0;
    logic st;
    logic done = 1'b0;
    e.instr = instr; e.pc = pc; e.alurs = alurs; e.rd = exp_rd; e.wd = wd;
    e.dst = dst; e.exc = exp_exc;
    wq.push_back(e);
    if (bus) begin
      b.addr = {alurs[31:2], 2'b00}; b.we = wr; b.be = exp_be; b.wdata = exp_wdata;
      bq.push_back(b);
    end
    drive_m(instr, pc, alurs, wd, dst, rd, wr, mt);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      st = Stall_M_O;
      if (st) nst++;
      if (dm_req) begin
        if (req_seen >= waits) begin
          dm_ready = 1'b1;
          dm_rdata = rdata;
        end
        req_seen++;
      end
      @(posedge clk);
      #1;
      dm_ready = 1'b0;
      dm_rdata = 32'h5A5A_5A5A;
      if (!st) begin
        done = 1'b1;
        break;
      end
    end
    chk({nm, "_done"}, {31'h0, done}, 32'h1);
    chk({nm, "_stalls"}, nst, exp_stalls);
  endtask

  initial begin
    reset = 1'b0;
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    drive_m(32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", Instr_W_O, 32'h0);
    chk("rst_pc",    PC_W_O,    32'h0000_3000);
    chk("rst_alurs", ALURS_W_O, 32'h0);
    chk("rst_rd",    RD_W_O,    32'h0);
    chk("rst_wd",    WD_W_O,    32'h0);
    chk("rst_dst",   {27'h0, Dst_W_O}, 32'h0);
    chk("rst_req",   {31'h0, dm_req},  32'h0);
    chk("rst_stall", {31'h0, Stall_M_O}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // Back-to-back ALU ops: no stalls, each reaches W one cycle later.
    do_op("alu0", 32'h0022_1820, 32'h3000, 32'h11, 32'h5, 5'd3, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 5'd0);
    do_op("alu1", 32'h0043_2020, 32'h3004, 32'h22, 32'h6, 5'd4, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 5'd0);
    do_op("alu2", 32'h0064_2820, 32'h3008, 32'h33, 32'h7, 5'd5, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 5'd0);
    do_op("alu3", 32'h0085_3020, 32'h300C, 32'h44, 32'h8, 5'd6, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 5'd0);
    // Stores of each width, varying ready latency.
    do_op("sw",   32'hAC00_0008, 32'h3010, 32'h08, 32'h1122_3344, 5'd0, 0, 1, 2'b00, 2, 32'h0BAD_0001, 32'h0, 4, 1, 4'b1111, 32'h1122_3344, 5'd0);
    do_op("sb",   32'hA000_0013, 32'h3014, 32'h13, 32'h0000_00AB, 5'd0, 0, 1, 2'b10, 0, 32'h0BAD_0002, 32'h0, 2, 1, 4'b1000, 32'hABAB_ABAB, 5'd0);
    do_op("sh12", 32'hA400_0012, 32'h3018, 32'h12, 32'h1234_CDEF, 5'd0, 0, 1, 2'b01, 0, 32'h0BAD_0003, 32'h0, 2, 1, 4'b1100, 32'hCDEF_CDEF, 5'd0);
    do_op("sh10", 32'hA400_0010, 32'h301C, 32'h10, 32'h0000_BEEF, 5'd0, 0, 1, 2'b01, 1, 32'h0BAD_0004, 32'h0, 3, 1, 4'b0011, 32'hBEEF_BEEF, 5'd0);
    // Load with immediate ready: raw word lands in RD_W_O.
    do_op("lw",   32'h8C08_0020, 32'h3020, 32'h20, 32'h0000_0099, 5'd8, 1, 0, 2'b00, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 1, 4'b1111, 32'h0, 5'd0);
    // Load+store flags together behave as a store; type 11 behaves as word.
    do_op("rdwr", 32'hAC09_0040, 32'h3024, 32'h40, 32'hCAFE_F00D, 5'd0, 1, 1, 2'b00, 0, 32'h7777_7777, 32'h0, 2, 1, 4'b1111, 32'hCAFE_F00D, 5'd0);
    do_op("mt11", 32'hAC0A_0044, 32'h3028, 32'h44, 32'h0102_0304, 5'd0, 0, 1, 2'b11, 0, 32'h7777_7777, 32'h0, 2, 1, 4'b1111, 32'h0102_0304, 5'd0);
`ifdef M_ALIGN_CHECK_EN
    do_op("lw22", 32'h8C09_0022, 32'h302C, 32'h22, 32'h0, 5'd9, 1, 0, 2'b00, 0, 32'h0BAD_F00D, 32'h0, 0, 0, 4'b0000, 32'h0, 5'd4);
    do_op("sh21", 32'hA400_0021, 32'h3030, 32'h21, 32'h0000_5566, 5'd0, 0, 1, 2'b01, 0, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 5'd5);
`else
    do_op("lw22", 32'h8C09_0022, 32'h302C, 32'h22, 32'h0, 5'd9, 1, 0, 2'b00, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 2, 1, 4'b1111, 32'h0, 5'd0);
    do_op("sh21", 32'hA400_0021, 32'h3030, 32'h21, 32'h0000_5566, 5'd0, 0, 1, 2'b01, 0, 32'h0, 32'h0, 2, 1, 4'b0011, 32'h5566_5566, 5'd0);
`endif
    drive_m(32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1;

    // Reset while BUSY abandons the access; a late dm_ready is ignored.
    begin
      bus_t b;
      b.addr = 32'h30; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'h0;
      bq.push_back(b);
    end
    drive_m(32'h8C0B_0030, 32'h3034, 32'h30, 32'h0, 5'd11, 1'b1, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("busy_req", {31'h0, dm_req}, 32'h1);
    reset = 1'b0;
    drive_m(32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_req",   {31'h0, dm_req}, 32'h0);
    chk("rst2_pc",    PC_W_O,    32'h0000_3000);
    chk("rst2_instr", Instr_W_O, 32'h0);
    dm_ready = 1'b1;
    dm_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_req",   {31'h0, dm_req},    32'h0);
      chk("stray_stall", {31'h0, Stall_M_O}, 32'h0);
      chk("stray_rd",    RD_W_O,             32'h0);
    end
    dm_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wq_empty", wq.size(), 32'h0);
    chk("bq_empty", bq.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
